// File: rtl/vc_ctrl_param.sv
// -----------------------------------------------------------------------------
// vc_ctrl_param -- per-input-VC packet controller for a wormhole router.
//
// Latches the route (output port / output VC) carried with a head flit, waits
// for the downstream VC to be unlocked, then requests the crossbar for every
// flit of the packet. It holds the downstream VC lock from the head send until
// the tail send. An age counter feeds the age-based switch allocator. A
// packet-length watchdog and protocol checks drive a sticky error flag.
//
// Ports:
//   clk       clock
//   rst_      synchronous active-low reset
//   bvalid    input buffer head holds a valid flit
//   btype     flit type of the buffer head (HEAD/DATA/TAIL/HEADTAIL)
//   port_in   routing result, sampled only on an accepted head
//   ovch_in   output VC, sampled only on an accepted head
//   ilck      downstream VC locked by another input VC, bit = port*NVCH+vch
//   irdy      downstream VC can take one flit this cycle, same indexing
//   grt       crossbar grant to this VC, one bit per output port
//   req       one-hot switch request toward the latched port
//   send      flit crosses the switch this cycle (buffer pops too)
//   olck      this VC holds the downstream VC lock
//   cur_port  latched output port
//   cur_ovch  latched output VC
//   age       saturating count of cycles spent requesting without a send
//   err       sticky protocol / length error, cleared only by reset
// -----------------------------------------------------------------------------
module vc_ctrl_param #(
  parameter int NPORT  = 5,
  parameter int NVCH   = 2,
  parameter int PORTW  = $clog2(NPORT),
  parameter int VCHW   = (NVCH > 1) ? $clog2(NVCH) : 1,
  parameter int AGEW   = 4,
  parameter int MAXLEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  bvalid,
  input  logic [1:0]            btype,
  input  logic [PORTW-1:0]      port_in,
  input  logic [VCHW-1:0]       ovch_in,
  input  logic [NPORT*NVCH-1:0] ilck,
  input  logic [NPORT*NVCH-1:0] irdy,
  input  logic [NPORT-1:0]      grt,
  output logic [NPORT-1:0]      req,
  output logic                  send,
  output logic                  olck,
  output logic [PORTW-1:0]      cur_port,
  output logic [VCHW-1:0]       cur_ovch,
  output logic [AGEW-1:0]       age,
  output logic                  err
);

  localparam logic [1:0] TYPE_HEAD     = 2'd0;
  localparam logic [1:0] TYPE_DATA     = 2'd1;
  localparam logic [1:0] TYPE_TAIL     = 2'd2;
  localparam logic [1:0] TYPE_HEADTAIL = 2'd3;

  localparam int FCW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VA   = 2'd1,
    S_ST   = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [PORTW-1:0] port_r;
  logic [VCHW-1:0]  ovch_r;
  logic [FCW-1:0]   fcnt;

  logic ilck_s, irdy_s, grt_s;
  logic rq;
  logic is_head, is_tail, port_ok;
  logic latch_route, set_err, olck_set, olck_clr, wdog_err;

  assign is_head  = (btype == TYPE_HEAD) || (btype == TYPE_HEADTAIL);
  assign is_tail  = (btype == TYPE_TAIL) || (btype == TYPE_HEADTAIL);
  assign port_ok  = int'(port_in) < NPORT;
  assign cur_port = port_r;
  assign cur_ovch = ovch_r;

  // Pick the downstream status bits for the latched (port, VC). Written as a
  // compare-and-select loop so an out-of-range ovch_r simply selects nothing.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    ilck_s = 1'b0;
    irdy_s = 1'b0;
    grt_s  = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (port_r == p[PORTW-1:0]) grt_s = grt[p];
      for (int v = 0; v < NVCH; v++) begin
        if (port_r == p[PORTW-1:0] && ovch_r == v[VCHW-1:0]) begin
          ilck_s = ilck[p*NVCH+v];
          irdy_s = irdy[p*NVCH+v];
        end
      end
    end
  end

  // The lock check only gates the head: once in ST this VC owns the lock.
  assign rq   = bvalid && (((state == S_VA) && !ilck_s) || (state == S_ST));
  assign send = rq && grt_s && irdy_s;

  always_comb begin
    req = '0;
    for (int p = 0; p < NPORT; p++) req[p] = rq && (port_r == p[PORTW-1:0]);
  end

  // Body flits past the length limit are still forwarded; only flag them.
  assign wdog_err = (state == S_ST) && send && !is_tail &&
                    (fcnt == FCW'(MAXLEN - 1));

  always_comb begin
    state_nx    = state;
    latch_route = 1'b0;
    set_err     = 1'b0;
    olck_set    = 1'b0;
    olck_clr    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bvalid) begin
          if (is_head && port_ok) begin
            latch_route = 1'b1;
            state_nx    = S_VA;
          end else begin
            // Unroutable head, or a body/tail flit with no packet open.
            set_err = 1'b1;
          end
        end
      end
      S_VA: begin
        if (send) begin
          if (btype == TYPE_HEADTAIL) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_ST;
            olck_set = 1'b1;
          end
        end
      end
      S_ST: begin
        if (send && is_tail) begin
          state_nx = S_IDLE;
          olck_clr = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    if (!rst_) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      port_r <= '0;
      ovch_r <= '0;
      olck   <= 1'b0;
      err    <= 1'b0;
      age    <= '0;
      fcnt   <= '0;
    end else begin
      if (latch_route) begin
        port_r <= port_in;
        ovch_r <= ovch_in;
      end

      if (olck_set)      olck <= 1'b1;
      else if (olck_clr) olck <= 1'b0;

      if (set_err || wdog_err) err <= 1'b1;

      // Head send restarts the count at 1; later sends count up, saturating
      // so an overlong packet cannot wrap back under the watchdog limit.
      if (send) begin
        if (state == S_VA)  fcnt <= FCW'(1);
        else if (fcnt != '1) fcnt <= fcnt + FCW'(1);
      end

      if (state == S_IDLE || send) age <= '0;
      else if (rq && age != '1)    age <= age + AGEW'(1);
    end
  end

endmodule

// File: tb/tb_vc_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_vc_ctrl_param -- self-checking bench for vc_ctrl_param.
//
// A packet-level reference model (route held / lock held / flit count / age /
// error) predicts req and send each cycle and the registered outputs after
// each edge. Directed sequences cover the documented scenarios and corners;
// a randomized packet source then exercises arbitrary lock, ready, grant and
// reset patterns.
// -----------------------------------------------------------------------------
module tb_vc_ctrl_param;

  localparam int NPORT  = 5;
  localparam int NVCH   = 2;
  localparam int PORTW  = $clog2(NPORT);
  localparam int VCHW   = (NVCH > 1) ? $clog2(NVCH) : 1;
  localparam int AGEW   = 4;
  localparam int MAXLEN = 4;
  localparam int AGEMAX = (1 << AGEW) - 1;
  localparam int FCMAX  = (1 << $clog2(MAXLEN + 1)) - 1;

  localparam logic [1:0] HEAD = 2'd0, DATA = 2'd1, TAIL = 2'd2, HT = 2'd3;

  logic                  clk = 1'b0;
  logic                  rst_;
  logic                  bvalid;
  logic [1:0]            btype;
  logic [PORTW-1:0]      port_in;
  logic [VCHW-1:0]       ovch_in;
  logic [NPORT*NVCH-1:0] ilck;
  logic [NPORT*NVCH-1:0] irdy;
  logic [NPORT-1:0]      grt;
  logic [NPORT-1:0]      req;
  logic                  send;
  logic                  olck;
  logic [PORTW-1:0]      cur_port;
  logic [VCHW-1:0]       cur_ovch;
  logic [AGEW-1:0]       age;
  logic                  err;

  always #5 clk = ~clk;

  vc_ctrl_param #(
    .NPORT(NPORT), .NVCH(NVCH), .AGEW(AGEW), .MAXLEN(MAXLEN)
  ) dut (
    .clk(clk), .rst_(rst_), .bvalid(bvalid), .btype(btype),
    .port_in(port_in), .ovch_in(ovch_in), .ilck(ilck), .irdy(irdy),
    .grt(grt), .req(req), .send(send), .olck(olck),
    .cur_port(cur_port), .cur_ovch(cur_ovch), .age(age), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: a packet is "routed" from head acceptance until
  // its last flit is sent; the lock is "held" from the head send until tail.
  bit m_route, m_lock, m_err, m_send;
  int m_port, m_vc, m_fcnt, m_age;

  function automatic bit bit_at(input logic [31:0] v, input int i);
    return ((v >> i) & 32'd1) != 32'd0;
  endfunction

  function automatic bit head_type(input logic [1:0] t);
    return t == HEAD || t == HT;
  endfunction

  function automatic bit tail_type(input logic [1:0] t);
    return t == TAIL || t == HT;
  endfunction

  task automatic model_reset();
    m_route = 0; m_lock = 0; m_err = 0;
    m_port = 0; m_vc = 0; m_fcnt = 0; m_age = 0;
  endtask

  // Called at a negedge with the inputs already applied: checks the
  // combinational outputs, advances the model over the next posedge and
  // checks the registered outputs at the following negedge.
  task automatic tick();
    int sel;
    bit rq, snd, was_route;
    logic [NPORT-1:0] ereq;
    #1;
    sel  = m_port * NVCH + m_vc;
    rq   = bvalid && m_route && (m_lock || !bit_at(32'(ilck), sel));
    snd  = rq && bit_at(32'(grt), m_port) && bit_at(32'(irdy), sel);
    ereq = rq ? NPORT'(1 << m_port) : '0;
    check("req", 32'(req), 32'(ereq));
    check("send", 32'(send), 32'(snd));
    m_send = snd;

    if (!rst_) begin
      model_reset();
    end else begin
      was_route = m_route;
      if (!m_route) begin
        if (bvalid) begin
          if (head_type(btype) && int'(port_in) < NPORT) begin
            m_route = 1; m_port = int'(port_in); m_vc = int'(ovch_in);
          end else begin
            m_err = 1;
          end
        end
      end else if (snd) begin
        if (!m_lock) begin
          m_fcnt = 1;
          if (btype == HT) m_route = 0;
          else             m_lock  = 1;
        end else begin
          if (!tail_type(btype) && m_fcnt == MAXLEN - 1) m_err = 1;
          if (m_fcnt < FCMAX) m_fcnt++;
          if (tail_type(btype)) begin m_route = 0; m_lock = 0; end
        end
      end
      if (!was_route || snd)        m_age = 0;
      else if (rq && m_age < AGEMAX) m_age++;
    end

    @(negedge clk);
    check("olck", 32'(olck), 32'(m_lock));
    check("err", 32'(err), 32'(m_err));
    check("age", 32'(age), 32'(m_age));
    check("cur_port", 32'(cur_port), 32'(m_port));
    check("cur_ovch", 32'(cur_ovch), 32'(m_vc));
    check("fcnt", 32'(dut.fcnt), 32'(m_fcnt));
  endtask

  task automatic drive(input bit bv, input logic [1:0] bt, input int p,
                       input int v);
    bvalid  = bv;
    btype   = bt;
    port_in = PORTW'(p);
    ovch_in = VCHW'(v);
    tick();
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    drive(0, DATA, 0, 0);
    rst_ = 1'b1;
  endtask

  // Random packet source: queue of flit types for the packet at the buffer head.
  logic [1:0] src_q[$];
  int src_port, src_vc;

  initial begin
    rst_ = 1'b0; bvalid = 1'b0; btype = DATA; port_in = '0; ovch_in = '0;
    ilck = '0; irdy = '1; grt = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset state, with the DUT already in a defined state.
    do_reset();
    check("rst_olck", 32'(olck), 32'd0);
    check("rst_age", 32'(age), 32'd0);

    // Single HEADTAIL to port 2 VC1, grant one cycle after the head.
    drive(1, HT, 2, 1);
    grt = 5'b00100;
    drive(1, HT, 2, 1);
    check("ht_no_lock", 32'(olck), 32'd0);
    drive(0, DATA, 0, 0);

    // 4-flit packet to port 3 VC0 with downstream VC locked for 3 cycles.
    grt = 5'b01000;
    ilck = '0; ilck[6] = 1'b1;
    drive(1, HEAD, 3, 0);
    repeat (3) drive(1, HEAD, 3, 0);
    ilck = '0;
    drive(1, HEAD, 3, 0);
    check("p4_lock", 32'(olck), 32'd1);
    drive(1, DATA, 0, 0);
    drive(1, DATA, 0, 0);
    drive(1, TAIL, 0, 0);
    check("p4_unlock", 32'(olck), 32'd0);
    check("p4_fcnt", 32'(dut.fcnt), 32'd4);
    check("p4_err", 32'(err), 32'd0);

    // Back-pressure in ST on port 1 VC1 (sel 3).
    grt = 5'b00010;
    drive(1, HEAD, 1, 1);
    drive(1, HEAD, 1, 1);
    drive(1, DATA, 0, 0);
    irdy = '1; irdy[3] = 1'b0;
    drive(1, DATA, 0, 0);
    drive(1, DATA, 0, 0);
    check("bp_age2", 32'(age), 32'd2);
    check("bp_hold", 32'(olck), 32'd1);
    irdy = '1;
    drive(1, DATA, 0, 0);
    check("bp_age_clr", 32'(age), 32'd0);
    drive(1, TAIL, 0, 0);

    // Watchdog: head + 4 data + tail with MAXLEN=4.
    grt = 5'b10000;
    drive(1, HEAD, 4, 1);
    drive(1, HEAD, 4, 1);
    drive(1, DATA, 0, 0);
    drive(1, DATA, 0, 0);
    check("wd_quiet", 32'(err), 32'd0);
    drive(1, DATA, 0, 0);
    check("wd_trip", 32'(err), 32'd1);
    drive(1, DATA, 0, 0);
    drive(1, TAIL, 0, 0);
    check("wd_sticky", 32'(err), 32'd1);
    check("wd_unlock", 32'(olck), 32'd0);

    // Protocol errors: stray DATA in IDLE, then a head to port 7.
    do_reset();
    check("pe_clr", 32'(err), 32'd0);
    drive(1, DATA, 0, 0);
    check("pe_data", 32'(err), 32'd1);
    do_reset();
    drive(1, HEAD, 7, 0);
    check("pe_port", 32'(err), 32'd1);
    drive(0, DATA, 0, 0);

    // Reset in the middle of a packet.
    do_reset();
    grt = 5'b00001;
    drive(1, HEAD, 0, 1);
    drive(1, HEAD, 0, 1);
    check("mr_lock", 32'(olck), 32'd1);
    rst_ = 1'b0;
    drive(1, DATA, 0, 1);
    rst_ = 1'b1;
    check("mr_olck", 32'(olck), 32'd0);
    drive(0, DATA, 0, 0);

    // Age saturation under long back-pressure.
    grt = 5'b00001; irdy = '1;
    drive(1, HEAD, 0, 0);
    drive(1, HEAD, 0, 0);
    irdy = '0;
    repeat (20) drive(1, DATA, 0, 0);
    check("age_sat", 32'(age), 32'(AGEMAX));
    irdy = '1;
    drive(1, DATA, 0, 0);
    drive(1, TAIL, 0, 0);

    // Randomized traffic.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit pre_route;
      if (src_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        int len;
        len = $urandom_range(1, 6);
        src_port = ($urandom_range(0, 19) == 0) ? $urandom_range(5, 7)
                                                : $urandom_range(0, NPORT - 1);
        src_vc = $urandom_range(0, NVCH - 1);
        if (len == 1) begin
          src_q.push_back(HT);
        end else begin
          src_q.push_back(HEAD);
          for (int k = 0; k < len - 2; k++) src_q.push_back(DATA);
          src_q.push_back(TAIL);
        end
      end
      rst_ = ($urandom_range(0, 199) != 0);
      ilck = NPORT*NVCH'($urandom) & NPORT*NVCH'($urandom);
      irdy = NPORT*NVCH'($urandom | $urandom);
      grt  = NPORT'($urandom);
      pre_route = m_route;
      if (src_q.size() != 0) begin
        bvalid  = ($urandom_range(0, 4) != 0);
        btype   = src_q[0];
        port_in = PORTW'(src_port);
        ovch_in = VCHW'(src_vc);
      end else begin
        // Occasionally present a stray body flit with no packet open.
        bvalid  = ($urandom_range(0, 99) == 0);
        btype   = DATA;
        port_in = PORTW'($urandom);
        ovch_in = VCHW'($urandom);
      end
      tick();
      if (!rst_) src_q.delete();
      else if (m_send && src_q.size() != 0) void'(src_q.pop_front());
      else if (!pre_route && bvalid && src_q.size() != 0 && src_port >= NPORT)
        src_q.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
